// File: rtl/swgbe_overrun_monitor.sv
// ============================================================================
// swgbe_overrun_monitor : 10GbE TX-path health events packed into a status word
// Revision 1.0
// ============================================================================
`default_nettype none

module swgbe_overrun_monitor #(
  parameter int CNT_W    = 16,
  parameter int RUN_W    = 12,
  parameter int CLR_HOLD = 4
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        tx_overflow,
  input  logic        tx_afull,
  input  logic        link_up,
  input  logic        sw_clr,
  output logic [31:0] status_word,
  output logic        clr_busy
);

  localparam int HOLD_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [RUN_W-1:0]  RUN_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLR_HOLD - 1);

  generate
    if ((CNT_W + RUN_W) != 28) begin : g_bad_widths
      $error("swgbe_overrun_monitor: CNT_W + RUN_W must equal 28");
    end
    if (CLR_HOLD < 1) begin : g_bad_hold
      $error("swgbe_overrun_monitor: CLR_HOLD must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              clr_busy_q, clr_busy_d;

  logic ovf_q, ovf_qq, afull_q, link_q, link_qq, clr_q, clr_qq;

  logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
  logic [RUN_W-1:0] afull_run_q, afull_run_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             link_lost_q, link_lost_d;
  logic [31:0]      status_q, status_d;

  logic             ovf_rise, link_fall, clr_rise;
  logic [RUN_W-1:0] run_inc;

  assign ovf_rise  = ovf_q & ~ovf_qq;
  assign link_fall = link_qq & ~link_q;
  assign clr_rise  = clr_q & ~clr_qq;
  assign run_inc   = (afull_run_q == RUN_MAX) ? afull_run_q : afull_run_q + RUN_W'(1);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ovf_q   <= 1'b0;
      ovf_qq  <= 1'b0;
      afull_q <= 1'b0;
      link_q  <= 1'b0;
      link_qq <= 1'b0;
      clr_q   <= 1'b0;
      clr_qq  <= 1'b0;
    end else begin
      ovf_q   <= tx_overflow;
      ovf_qq  <= ovf_q;
      afull_q <= tx_afull;
      link_q  <= link_up;
      link_qq <= link_q;
      clr_q   <= sw_clr;
      clr_qq  <= clr_q;
    end
  end

  // Once started, the hold runs to completion regardless of sw_clr.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_rise) begin
          state_d = ST_CLEAR;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_CLEAR: begin
        if (hold_q == '0) begin
          state_d = clr_q ? ST_WAIT_REL : ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!clr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    clr_busy_d = (state_d == ST_CLEAR);
  end

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    afull_run_d   = afull_run_q;
    max_run_d     = max_run_q;
    ovf_sticky_d  = ovf_sticky_q;
    link_lost_d   = link_lost_q;
    if (state_q == ST_CLEAR) begin
      overrun_cnt_d = '0;
      afull_run_d   = '0;
      max_run_d     = '0;
      ovf_sticky_d  = 1'b0;
      link_lost_d   = 1'b0;
    end else begin
      if (ovf_rise) begin
        ovf_sticky_d = 1'b1;
        if (overrun_cnt_q != CNT_MAX) overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
      end
      if (link_fall) link_lost_d = 1'b1;
      if (afull_q) begin
        afull_run_d = run_inc;
        if (run_inc > max_run_q) max_run_d = run_inc;
      end else begin
        afull_run_d = '0;
      end
    end
    status_d = {ovf_sticky_q, link_lost_q, (max_run_q != '0), link_q,
                max_run_q, overrun_cnt_q};
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      clr_busy_q    <= 1'b0;
      overrun_cnt_q <= '0;
      afull_run_q   <= '0;
      max_run_q     <= '0;
      ovf_sticky_q  <= 1'b0;
      link_lost_q   <= 1'b0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      clr_busy_q    <= clr_busy_d;
      overrun_cnt_q <= overrun_cnt_d;
      afull_run_q   <= afull_run_d;
      max_run_q     <= max_run_d;
      ovf_sticky_q  <= ovf_sticky_d;
      link_lost_q   <= link_lost_d;
      status_q      <= status_d;
    end
  end

  assign status_word = status_q;
  assign clr_busy    = clr_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_swgbe_overrun_monitor.sv
// ============================================================================
// tb_swgbe_overrun_monitor : directed self-checking bench for the monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_swgbe_overrun_monitor;

  logic        user_clk;
  logic        user_rst_n;
  logic        tx_overflow;
  logic        tx_afull;
  logic        link_up;
  logic        sw_clr;
  logic [31:0] status_word;
  logic        clr_busy;
  logic [31:0] status_word_sat;
  logic        clr_busy_sat;

  int n_checks;
  int n_fail;

  swgbe_overrun_monitor #(.CNT_W(16), .RUN_W(12), .CLR_HOLD(4)) u_dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .tx_overflow (tx_overflow),
    .tx_afull    (tx_afull),
    .link_up     (link_up),
    .sw_clr      (sw_clr),
    .status_word (status_word),
    .clr_busy    (clr_busy)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  swgbe_overrun_monitor #(.CNT_W(6), .RUN_W(22), .CLR_HOLD(4)) u_sat (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .tx_overflow (tx_overflow),
    .tx_afull    (tx_afull),
    .link_up     (link_up),
    .sw_clr      (sw_clr),
    .status_word (status_word_sat),
    .clr_busy    (clr_busy_sat)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_rst_n  = 1'b0;
    tx_overflow = 1'b0;
    tx_afull    = 1'b0;
    link_up     = 1'b1;
    sw_clr      = 1'b0;
    tick(2);
    user_rst_n = 1'b1;
    tick(3);
  endtask

  task automatic pulse_ovf();
    tx_overflow = 1'b1;
    tick(1);
    tx_overflow = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    user_rst_n  = 1'b0;
    tx_overflow = 1'b0;
    tx_afull    = 1'b0;
    link_up     = 1'b1;
    sw_clr      = 1'b0;
    tick(2);
    n_checks++;
    if (status_word !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected %h", status_word, 32'h0);
    end
    user_rst_n = 1'b1;
    tick(3);
    n_checks++;
    if (status_word !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL reset_release_status: got %h expected %h", status_word, 32'h1000_0000);
    end
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clr_busy: got %b expected 0", clr_busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_overflow = 1'b1;
    tick(2);
    n_checks++;
    if (status_word[15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL ovf_latency_early: got %h expected %h", status_word[15:0], 16'h0000);
    end
    tick(1);
    n_checks++;
    if (status_word !== 32'h9000_0001) begin
      n_fail++;
      $display("FAIL ovf_latency_3: got %h expected %h", status_word, 32'h9000_0001);
    end
    tick(7);
    tx_overflow = 1'b0;
    tick(5);
    tx_overflow = 1'b1;
    tick(1);
    tx_overflow = 1'b0;
    tick(4);
    n_checks++;
    if (status_word !== 32'h9000_0002) begin
      n_fail++;
      $display("FAIL ovf_edge_count: got %h expected %h", status_word, 32'h9000_0002);
    end
  endtask

  task automatic test_afull();
    do_reset();
    tx_afull = 1'b1;
    tick(7);
    tx_afull = 1'b0;
    tick(3);
    tx_afull = 1'b1;
    tick(3);
    tx_afull = 1'b0;
    tick(4);
    n_checks++;
    if (status_word !== 32'h3007_0000) begin
      n_fail++;
      $display("FAIL afull_max_run: got %h expected %h", status_word, 32'h3007_0000);
    end
    tx_afull = 1'b1;
    tick(5000);
    tx_afull = 1'b0;
    tick(4);
    n_checks++;
    if (status_word !== 32'h3FFF_0000) begin
      n_fail++;
      $display("FAIL afull_saturate: got %h expected %h", status_word, 32'h3FFF_0000);
    end
  endtask

  task automatic test_link();
    do_reset();
    link_up = 1'b0;
    tick(4);
    n_checks++;
    if (status_word !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL link_drop: got %h expected %h", status_word, 32'h4000_0000);
    end
    link_up = 1'b1;
    tick(4);
    n_checks++;
    if (status_word !== 32'h5000_0000) begin
      n_fail++;
      $display("FAIL link_restore: got %h expected %h", status_word, 32'h5000_0000);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70; i++) pulse_ovf();
    tick(3);
    n_checks++;
    if (status_word_sat !== 32'h9000_003F) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %h expected %h", status_word_sat, 32'h9000_003F);
    end
    for (int i = 0; i < 5; i++) pulse_ovf();
    tick(3);
    n_checks++;
    if (status_word_sat !== 32'h9000_003F) begin
      n_fail++;
      $display("FAIL cnt_no_wrap: got %h expected %h", status_word_sat, 32'h9000_003F);
    end
    n_checks++;
    if (status_word !== 32'h9000_004B) begin
      n_fail++;
      $display("FAIL cnt_wide_75: got %h expected %h", status_word, 32'h9000_004B);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    do_reset();
    pulse_ovf();
    tx_afull = 1'b1;
    tick(3);
    tx_afull = 1'b0;
    tick(4);
    n_checks++;
    if (status_word !== 32'hB003_0001) begin
      n_fail++;
      $display("FAIL pre_clear_status: got %h expected %h", status_word, 32'hB003_0001);
    end
    busy_cnt = 0;
    sw_clr = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (clr_busy === 1'b1) busy_cnt++;
      if (i == 1) begin
        n_checks++;
        if (clr_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_busy_early: got %b expected 0", clr_busy);
        end
      end
      if (i == 2) begin
        tx_overflow = 1'b1;
        n_checks++;
        if (clr_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL clr_busy_assert: got %b expected 1", clr_busy);
        end
      end
      if (i == 3) tx_overflow = 1'b0;
      if (i == 4) begin
        n_checks++;
        if (status_word !== 32'h1000_0000) begin
          n_fail++;
          $display("FAIL clear_status: got %h expected %h", status_word, 32'h1000_0000);
        end
      end
      if (i == 7) tx_overflow = 1'b1;
      if (i == 8) tx_overflow = 1'b0;
      if (i == 12) begin
        n_checks++;
        if (status_word !== 32'h9000_0001) begin
          n_fail++;
          $display("FAIL count_after_clear: got %h expected %h", status_word, 32'h9000_0001);
        end
      end
    end
    n_checks++;
    if (busy_cnt !== 4) begin
      n_fail++;
      $display("FAIL clr_busy_width: got %0d expected 4", busy_cnt);
    end
    n_checks++;
    if (status_word !== 32'h9000_0001) begin
      n_fail++;
      $display("FAIL held_no_reclear: got %h expected %h", status_word, 32'h9000_0001);
    end
    sw_clr = 1'b0;
    tick(6);
    n_checks++;
    if ({clr_busy, status_word} !== {1'b0, 32'h9000_0001}) begin
      n_fail++;
      $display("FAIL release_no_reclear: got %b/%h expected 0/%h", clr_busy, status_word, 32'h9000_0001);
    end
  endtask

  task automatic test_short_clear();
    int busy_cnt;
    busy_cnt = 0;
    sw_clr = 1'b1;
    tick(1);
    sw_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (clr_busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 4) begin
      n_fail++;
      $display("FAIL short_clr_width: got %0d expected 4", busy_cnt);
    end
    n_checks++;
    if (status_word !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL short_clr_status: got %h expected %h", status_word, 32'h1000_0000);
    end
  endtask

  task automatic test_reset_mid_clear();
    pulse_ovf();
    tick(3);
    sw_clr = 1'b1;
    tick(3);
    n_checks++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_clear_busy: got %b expected 1", clr_busy);
    end
    user_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clr_busy, status_word} !== 33'h0) begin
      n_fail++;
      $display("FAIL async_reset_mid_clear: got %b/%h expected 0/%h", clr_busy, status_word, 32'h0);
    end
    sw_clr = 1'b0;
    tick(2);
    user_rst_n = 1'b1;
    tick(3);
    pulse_ovf();
    tick(3);
    n_checks++;
    if ({clr_busy, status_word} !== {1'b0, 32'h9000_0001}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b/%h expected 0/%h", clr_busy, status_word, 32'h9000_0001);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_overflow();
    test_afull();
    test_link();
    test_saturation();
    test_clear();
    test_short_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
